mem_arbiter: RTL

Two-requester arbiter sharing the single 8-bit memory port between instruction fetch (device 1, read-only) and the load/store stage (device 2, read/write). Sits between the pipeline stages and memory: latches one request, issues a one-cycle memory strobe, waits for the memory acknowledge (with timeout), and returns read data plus a one-cycle done pulse to the granted requester. Fairness is round-robin.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets instruction fetch (device 1) and load/store (device 2)
// share one memory port: one strobe per access, ack wait with timeout, done pulse back.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  device_1_mem_en,
  input  logic [ADDR_WIDTH-1:0] device_1_mem_addr,
  output logic                  device_1_do_ack,
  input  logic                  device_2_mem_en,
  input  logic                  device_2_mem_we,
  input  logic [ADDR_WIDTH-1:0] device_2_mem_addr,
  input  logic [DATA_WIDTH-1:0] device_2_mem_di,
  output logic                  device_2_do_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Last WAIT cycle index: counter starts at 0 in the first WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;  // 1 = device 2 holds / last held the grant
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_di_q, mem_di_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack1_q, ack1_d;
  logic                  ack2_q, ack2_d;
  logic                  berr_q, berr_d;
  logic                  grant2;
  logic                  finish;
  logic                  timeout;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_en_d   = 1'b0;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_di_d   = mem_di_q;
    rdata_d    = rdata_q;
    ack1_d     = 1'b0;
    ack2_d     = 1'b0;
    berr_d     = 1'b0;
    grant2     = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (device_1_mem_en || device_2_mem_en) begin
          grant2     = device_2_mem_en && (!device_1_mem_en || !last_q);
          last_d     = grant2;
          mem_en_d   = 1'b1;
          mem_we_d   = grant2 ? device_2_mem_we : 1'b0;
          mem_addr_d = grant2 ? device_2_mem_addr : device_1_mem_addr;
          mem_di_d   = grant2 ? device_2_mem_di : '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (mem_ack) finish = 1'b1;
        else         state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          finish = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Completion: an ack always beats a same-cycle timeout expiry.
    if (finish) begin
      state_d = S_DONE;
      ack1_d  = !last_q;
      ack2_d  = last_q;
      berr_d  = timeout;
      if (mem_ack && !mem_we_q) rdata_d = mem_do;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      rdata_q    <= '0;
      ack1_q     <= 1'b0;
      ack2_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
      rdata_q    <= rdata_d;
      ack1_q     <= ack1_d;
      ack2_q     <= ack2_d;
      berr_q     <= berr_d;
    end
  end

  assign device_1_do_ack = ack1_q;
  assign device_2_do_ack = ack2_q;
  assign rdata           = rdata_q;
  assign bus_error       = berr_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_di          = mem_di_q;

endmodule
